// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO and programmable bit period.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx
);

  // state    | meaning
  // IDLE     | line high, waiting for a byte in the FIFO
  // START    | driving the start bit (0)
  // DATA     | driving data bits 0..7, LSB first
  // PARITY   | driving the even parity bit (parity build only)
  // STOP     | driving the stop bit (1); chains straight into the next frame
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
  localparam logic PAR_EN = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic PAR_EN = 1'b0;
`endif

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          overflow;
  logic [15:0]   baud_div;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_done, busy;
  logic          wr_txdata, wr_status, wr_baud;
  logic          push, pop;
  logic [7:0]    fifo_rdata;
  logic [31:0]   status;
  logic          unused_bits;
`ifdef UART_TX_PARITY_EN
  logic          par_bit;
`endif

  assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16]};

  assign wr_txdata  = ce & we & (addr[3:2] == 2'b00);
  assign wr_status  = ce & we & (addr[3:2] == 2'b01);
  assign wr_baud    = ce & we & (addr[3:2] == 2'b10);

  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_rdata = fifo_mem[rd_ptr];
  assign bit_done   = (bit_cnt == 16'd0);
  assign busy       = (state != IDLE);

  // Fullness is judged before any same-edge pop, so a write to a full FIFO always drops.
  assign push = wr_txdata & ~fifo_full;
  assign pop  = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      baud_div   <= BAUD_DIV_RESET;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
      else if (pop && !push) fifo_count <= fifo_count - CNT_ONE;
      if (wr_status && data_i[3]) overflow <= 1'b0;
      if (wr_txdata && fifo_full) overflow <= 1'b1;
      if (wr_baud) baud_div <= data_i[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= fifo_rdata;
            bit_cnt <= baud_div;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^fifo_rdata;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= baud_div;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= baud_div;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            bit_cnt <= baud_div;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift   <= fifo_rdata;
              bit_cnt <= baud_div;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
`ifdef UART_TX_PARITY_EN
              par_bit <= ^fifo_rdata;
`endif
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign status = {16'b0, 8'(fifo_count), 3'b0, PAR_EN, overflow, fifo_empty, fifo_full, busy};

  always_comb begin
    data_o = 32'd0;
    if (ce && !we) begin
      case (addr[3:2])
        2'b01:   data_o = status;
        2'b10:   data_o = {16'b0, baud_div};
        default: data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that responds on the CPU data-memory bus (ce/we/addr/data) as a slave peer of data_ram. The CPU writes bytes into a transmit FIFO; an internal state machine serialises them as 8N1 frames, LSB first, on `tx` at a programmable bit period. The top level steers `ce` to this block or to data_ram by upper-address decode; this block decodes only `addr[3:2]`.

## Interface
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, 2..128.
- `BAUD_DIV_RESET`, 16'd433: reset value of BAUDDIV. Bit period is BAUDDIV+1 clocks.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  chip enable from the CPU data bus.
- `we`  in  1  1 = write, 0 = read. Qualified by `ce`.
- `addr`  in  32  byte address; only `[3:2]` decoded.
- `data_i`  in  32  write data from the CPU.
- `data_o`  out  32  read data to the CPU. Combinational.
- `tx`  out  1  serial output, registered, idle high.

## Operation
- Register map, by `addr[3:2]`:
  - 00 TXDATA, write-only. A write pushes `data_i[7:0]`. Reads return 0.
  - 01 STATUS, read. bit0 busy (state != IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits[15:8] fifo count, others 0. Writing 1 to bit3 clears overflow; other bits are ignored.
  - 10 BAUDDIV, read/write, bits[15:0]. Upper bits read 0.
  - 11: reads return 0; writes are ignored.
- `data_o` is 0 whenever `ce`=0 or `we`=1.
- Push rule:
  - If full at the write edge, the byte is dropped and overflow is set. This holds even if a pop occurs on the same edge.
  - Otherwise the byte is pushed.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- State machine: IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE: if the FIFO is not empty, pop into the shift register, load the bit counter with BAUDDIV, clear the bit index, and go to START with `tx`=0.
  - START: when the bit counter reaches 0, reload it, drive `tx`=shift[0], and go to DATA.
  - DATA: at each bit-counter expiry, shift right and increment the index. After index 7 expires, drive `tx`=1 and go to STOP (or to PARITY).
  - STOP: at expiry, if the FIFO is not empty, pop and go directly to START with `tx`=0 (back-to-back frames, no idle gap). Otherwise go to IDLE with `tx`=1.
- The bit counter counts down from BAUDDIV to 0, so each bit lasts BAUDDIV+1 clocks.
- A BAUDDIV write mid-frame takes effect at the next counter reload, i.e. the next bit boundary. The current bit is unaffected.
- BAUDDIV=0 is legal and gives 1 clock per bit.
- Reset (asynchronous, at any time including mid-frame):
  - `tx`=1 immediately, state IDLE, FIFO empty, count 0.
  - overflow=0, BAUDDIV=BAUD_DIV_RESET.
  - The frame in progress is abandoned.

## Timing
- A write is captured on edge E0 (ce=1, we=1, addr[3:2]=00).
- If IDLE, the pop happens at E1 and `tx` falls after E1. Write-to-start-bit latency is 1 clock.
- A full frame occupies 10×(BAUDDIV+1) clocks, or 11×(BAUDDIV+1) with parity.
- STATUS and FIFO count reflect the state registered at the last edge. A write on E0 is visible in STATUS from E0 onward.
- No wait states: every access completes in the cycle it is presented.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds the PARITY state between DATA and STOP.
  - `tx` carries even parity (XOR of the 8 data bits) for one bit period.
  - STATUS bit4 reads 1.
- Not defined:
  - No PARITY state; frames are 8N1.
  - STATUS bit4 reads 0.

## Test plan
- Reset and idle: assert `rst`=0 mid-frame.
  - Required: `tx`=1 immediately, and STATUS reads 0x0000_0004 after release.
  - Required: BAUDDIV reads BAUD_DIV_RESET.
- Single byte: BAUDDIV=3, write 0xA5.
  - Required: starting 1 clock after the write edge, `tx` holds each of 0,1,0,1,0,0,1,0,1,1 for 4 clocks.
  - Required: busy=1 for 40 clocks, then STATUS=0x0000_0004.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles (BAUDDIV=0).
  - Required: 20 consecutive frame bits with no idle gap, i.e. 0,0×8,1,0,1×8,1.
- Overflow: 10 writes on consecutive cycles while IDLE (FIFO_DEPTH=8).
  - Required: after the 10th write, count=8, full=1, overflow=1.
  - Required: bytes 1–9 are transmitted in order and byte 10 never appears.
  - Required: writing STATUS=0x8 clears overflow.
- Baud change mid-frame: BAUDDIV=7, write 0x55, then write BAUDDIV=1 during data bit 2.
  - Required: bit 2 lasts 8 clocks and bits 3–7 and stop last 2 clocks each.
- Parity build (`UART_TX_PARITY_EN`): write 0x07.
  - Required: a parity bit of 1 follows data bit 7, and the frame is 11 bit periods.
